// File: rtl/instruction_register.sv
// JTAG instruction register: IR_WIDTH-bit capture/shift chain with an update shadow.
// Optional macro IR_SHIFT_GUARD_EN rejects updates that did not follow a full-length shift.
module instruction_register #(
    parameter int                  IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0] RESET_INSTR = {IR_WIDTH{1'b1}}
) (
    input  logic                ClockIR,
    input  logic                ResetN,
    input  logic                TDI,
    input  logic [IR_WIDTH-3:0] DI,
    input  logic                CaptureIR,
    input  logic                ShiftIR,
    input  logic                UpdateIR,
    output logic                TDO,
    output logic [IR_WIDTH-1:0] Q,
    output logic                UpdateDone,
    output logic                ShortShift
);

    logic [IR_WIDTH-1:0] r_shift_reg;
    logic [IR_WIDTH-1:0] r_q;
    logic                r_update_done;
    logic                w_accept;

`ifdef IR_SHIFT_GUARD_EN
    localparam int                CW      = $clog2(IR_WIDTH + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(IR_WIDTH);

    logic [CW-1:0] r_shift_count;
    logic          r_short_shift;

    // The count is sampled before this edge's clear, so capture+update still sees it.
    always_comb begin
        w_accept = UpdateIR && (r_shift_count == CNT_MAX);
    end

    always_ff @(posedge ClockIR) begin
        if (!ResetN) begin
            r_shift_count <= '0;
            r_short_shift <= 1'b0;
        end else begin
            if (CaptureIR || UpdateIR) begin
                r_shift_count <= '0;
            end else if (ShiftIR && (r_shift_count != CNT_MAX)) begin
                r_shift_count <= r_shift_count + 1'b1;
            end

            if (UpdateIR) begin
                r_short_shift <= !w_accept;
            end
        end
    end

    assign ShortShift = r_short_shift;
`else
    always_comb begin
        w_accept = UpdateIR;
    end

    assign ShortShift = 1'b0;
`endif

    always_ff @(posedge ClockIR) begin
        if (!ResetN) begin
            r_shift_reg   <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
            r_q           <= RESET_INSTR;
            r_update_done <= 1'b0;
        end else begin
            if (CaptureIR) begin
                r_shift_reg <= {DI, 2'b01};
            end else if (ShiftIR) begin
                r_shift_reg <= {TDI, r_shift_reg[IR_WIDTH-1:1]};
            end

            // Shadow loads the chain as it stood before this edge.
            if (w_accept) begin
                r_q <= r_shift_reg;
            end
            r_update_done <= w_accept;
        end
    end

    assign TDO        = r_shift_reg[0];
    assign Q          = r_q;
    assign UpdateDone = r_update_done;

endmodule
